// File: rtl/fp_isqrt_seed_if.sv
// fp_isqrt_seed_if: sample bus (valid_in/float_in/error_in/hold in, seed_out/half_x_out/x_delay_out/ready/error_out/err_code out)
interface fp_isqrt_seed_if;
  logic        valid_in;
  logic [31:0] float_in;
  logic        error_in;
  logic        hold;
  logic [30:0] seed_out;
  logic [30:0] half_x_out;
  logic [30:0] x_delay_out;
  logic        ready;
  logic        error_out;
  logic [1:0]  err_code;
  modport master (output valid_in, float_in, error_in, hold,
                  input seed_out, half_x_out, x_delay_out, ready, error_out, err_code);
  modport slave  (input valid_in, float_in, error_in, hold,
                  output seed_out, half_x_out, x_delay_out, ready, error_out, err_code);
endinterface

// File: rtl/fp_isqrt_seed_pipe.sv
// fp_isqrt_seed_pipe: 2-stage inverse-sqrt seed pipeline (clk, rst, bus: sample in, seed/half_x/x_delay/ready/error out)
module fp_isqrt_seed_pipe #(
  parameter logic [31:0] MAGIC = 32'h5F3759DF
) (
  input logic            clk,
  input logic            rst,
  fp_isqrt_seed_if.slave bus
);
  logic [7:0]  exp_in;
  logic [1:0]  cls_in;
  logic        v1;
  logic [30:0] x1;
  logic        e1;
  logic [1:0]  cls1;
  logic [30:0] seed_nxt;
  logic [30:0] half_nxt;
  always_comb begin
    exp_in   = bus.float_in[30:23];
    cls_in   = &exp_in ? 2'b11 : ~|exp_in ? 2'b01 : bus.float_in[31] ? 2'b10 : 2'b00;
    seed_nxt = |cls1 ? 31'd0 : MAGIC[30:0] - {1'b0, x1[30:1]};
    half_nxt = (|cls1 || x1[30:23] == 8'd1) ? 31'd0 : {x1[30:23] - 8'd1, x1[22:0]};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      v1              <= 1'b0;
      x1              <= '0;
      e1              <= 1'b0;
      cls1            <= 2'b00;
      bus.ready       <= 1'b0;
      bus.seed_out    <= '0;
      bus.half_x_out  <= '0;
      bus.x_delay_out <= '0;
      bus.error_out   <= 1'b0;
      bus.err_code    <= 2'b00;
    end else if (!bus.hold) begin
      v1        <= bus.valid_in;
      bus.ready <= v1;
      if (bus.valid_in) begin
        x1   <= bus.float_in[30:0];
        e1   <= bus.error_in;
        cls1 <= cls_in;
      end
      if (v1) begin
        bus.seed_out    <= seed_nxt;
        bus.half_x_out  <= half_nxt;
        bus.x_delay_out <= x1;
        bus.error_out   <= e1 | (|cls1);
        bus.err_code    <= cls1;
      end
    end
  end
endmodule

// File: tb/tb_fp_isqrt_seed_pipe.sv
// tb_fp_isqrt_seed_pipe: directed self-checking bench for fp_isqrt_seed_pipe
module tb_fp_isqrt_seed_pipe;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  fp_isqrt_seed_if bus();
  fp_isqrt_seed_pipe dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic v, input logic [31:0] f, input logic e);
    bus.valid_in = v;
    bus.float_in = f;
    bus.error_in = e;
  endtask
  task automatic expect_out(input string tag, input logic rdy, input logic [30:0] seed,
                            input logic [30:0] half, input logic [30:0] xd,
                            input logic eo, input logic [1:0] code);
    check({tag, ".ready"}, 32'(bus.ready), 32'(rdy));
    check({tag, ".seed"}, 32'(bus.seed_out), 32'(seed));
    check({tag, ".half"}, 32'(bus.half_x_out), 32'(half));
    check({tag, ".xdel"}, 32'(bus.x_delay_out), 32'(xd));
    check({tag, ".err"}, 32'(bus.error_out), 32'(eo));
    check({tag, ".code"}, 32'(bus.err_code), 32'(code));
  endtask
  logic [31:0] ev_in   [4] = '{32'h80000000, 32'hBF800000, 32'h7FC00000, 32'h00000001};
  logic [1:0]  ev_code [4] = '{2'b01, 2'b10, 2'b11, 2'b01};
  initial begin
    bus.hold = 1'b0;
    drive(1'b1, 32'h3F800000, 1'b0);
    tick;
    tick;
    expect_out("reset", 1'b0, 31'h0, 31'h0, 31'h0, 1'b0, 2'b00);
    rst = 1'b0;
    tick;
    drive(1'b0, 32'h0, 1'b0);
    tick;
    expect_out("one", 1'b1, 31'h3F7759DF, 31'h3F000000, 31'h3F800000, 1'b0, 2'b00);
    tick;
    check("bubble.ready", 32'(bus.ready), 32'd0);
    drive(1'b1, 32'h40800000, 1'b0);
    tick;
    drive(1'b1, 32'h3F800000, 1'b0);
    tick;
    expect_out("four", 1'b1, 31'h3EF759DF, 31'h40000000, 31'h40800000, 1'b0, 2'b00);
    drive(1'b0, 32'h0, 1'b0);
    tick;
    expect_out("b2b_one", 1'b1, 31'h3F7759DF, 31'h3F000000, 31'h3F800000, 1'b0, 2'b00);
    tick;
    expect_out("idle_keep", 1'b0, 31'h3F7759DF, 31'h3F000000, 31'h3F800000, 1'b0, 2'b00);
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, ev_in[i], 1'b0);
      tick;
      drive(1'b0, 32'h0, 1'b0);
      tick;
      expect_out($sformatf("class%0d", i), 1'b1, 31'h0, 31'h0, ev_in[i][30:0], 1'b1, ev_code[i]);
    end
    drive(1'b1, 32'h3F800000, 1'b1);
    tick;
    drive(1'b1, 32'h00800000, 1'b0);
    tick;
    expect_out("err_in", 1'b1, 31'h3F7759DF, 31'h3F000000, 31'h3F800000, 1'b1, 2'b00);
    drive(1'b0, 32'h0, 1'b0);
    tick;
    expect_out("exp1", 1'b1, 31'h5EF759DF, 31'h0, 31'h00800000, 1'b0, 2'b00);
    drive(1'b1, 32'h3F800000, 1'b0);
    tick;
    drive(1'b1, 32'h40800000, 1'b0);
    tick;
    expect_out("pre_hold", 1'b1, 31'h3F7759DF, 31'h3F000000, 31'h3F800000, 1'b0, 2'b00);
    drive(1'b1, 32'h40000000, 1'b0);
    bus.hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick;
      expect_out($sformatf("hold%0d", i), 1'b1, 31'h3F7759DF, 31'h3F000000, 31'h3F800000, 1'b0, 2'b00);
    end
    bus.hold = 1'b0;
    tick;
    expect_out("rel_four", 1'b1, 31'h3EF759DF, 31'h40000000, 31'h40800000, 1'b0, 2'b00);
    drive(1'b0, 32'h0, 1'b0);
    tick;
    expect_out("rel_two", 1'b1, 31'h3F3759DF, 31'h3F800000, 31'h40000000, 1'b0, 2'b00);
    tick;
    check("rel_end.ready", 32'(bus.ready), 32'd0);
    drive(1'b1, 32'h40800000, 1'b0);
    tick;
    tick;
    check("pre_rst.ready", 32'(bus.ready), 32'd1);
    bus.hold = 1'b1;
    rst = 1'b1;
    tick;
    expect_out("rst_hold", 1'b0, 31'h0, 31'h0, 31'h0, 1'b0, 2'b00);
    rst = 1'b0;
    bus.hold = 1'b0;
    drive(1'b0, 32'h0, 1'b0);
    tick;
    tick;
    check("post_rst.ready", 32'(bus.ready), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
